mem: RTL and testbench
======================

Name: mem

Overview:
- MEM stage of the RISC-V pipeline. Sits between ex_mem and mem_wb.
- Passes ALU results straight through.
- Executes loads and stores as a sequence of byte transfers on the memory controller's byte-wide data port.
- Holds the pipeline with a stall request while an access is in flight.
- Assembles load data, sign- or zero-extended, into the rd value that mem_wb consumes.

Parameters:
- None. Widths come from config.v: RegBus is 32 bits, RegAddrBus is 5 bits.

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset. Asynchronous, active-low.
- ex_rd_data  in  32  Result from ex_mem; for stores, don't-care.
- ex_rd_addr  in  5  Destination register.
- ex_rd_enable  in  1  Register write enable.
- ex_mem_load  in  1  Instruction is a load.
- ex_mem_store  in  1  Instruction is a store. Never high together with ex_mem_load.
- ex_mem_funct3  in  3  RISC-V funct3 for the load/store.
- ex_mem_addr  in  32  Effective byte address.
- ex_mem_sdata  in  32  Store data.
- mem_grant  in  1  Memory controller accepted the byte presented this cycle.
- mem_din  in  8  Read byte. Valid the cycle after a read grant.
- mem_req  out  1  Byte transfer request.
- mem_we  out  1  1 = write, 0 = read.
- mem_a  out  32  Byte address.
- mem_dout  out  8  Write byte.
- mem_stall_req  out  1  Hold IF/ID/EX and ex_mem.
- mem_rd_data  out  32  To mem_wb.
- mem_rd_addr  out  5  To mem_wb.
- mem_rd_enable  out  1  To mem_wb.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; byte counters and the data buffer clear.
  - While rst=0, all outputs are forced to 0, including the combinational ones.
- Access size:
  - funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, 1x = 4 bytes.
  - funct3[2]=1 selects zero-extension for loads.
- Byte order and addressing:
  - Little-endian. Byte i is at ex_mem_addr+i, with 32-bit wrap-around.
  - No alignment check; misaligned accesses are legal.
- State IDLE:
  - Not a load or store: outputs are combinational pass-through of ex_rd_*; mem_stall_req=0; mem_req=0.
  - Load or store: latch op, address, store data and rd fields. mem_stall_req=1 combinationally in this same cycle; mem_rd_enable=0. Next state is ACCESS.
- State ACCESS:
  - mem_req=1, mem_we=store, mem_a=base+issue_cnt, mem_dout=sdata[8*issue_cnt+:8].
  - On mem_grant, issue_cnt increments.
  - Without a grant, all request outputs hold unchanged.
  - On the grant of the last byte: a store goes to DONE; a load goes to WAIT.
  - mem_req drops in the cycle after the last grant.
- Load byte capture:
  - A one-cycle-delayed copy of (grant & read) marks mem_din valid.
  - The byte is written into buffer byte recv_cnt, then recv_cnt increments.
- State WAIT:
  - mem_req=0. Captures the final byte. Next state is DONE.
- State DONE (one cycle):
  - mem_stall_req=0.
  - mem_rd_addr and mem_rd_enable come from the latched fields.
  - mem_rd_data = buffered load data extended per size and sign (loads), or latched rd_data (stores).
  - Next state is IDLE.
  - The stall controller advances ex_mem when mem_stall_req falls, so IDLE sees the next instruction.
- mem_stall_req is high from the detect cycle through ACCESS and WAIT.
- mem_rd_enable=0 in ACCESS and WAIT.
- Latency with continuous grants:
  - LW: stall for 6 cycles, result in cycle 6.
  - LB: stall for 3 cycles.
  - SW: stall for 5 cycles, DONE in cycle 5.
- A grant while mem_req=0 is ignored.
- mem_din is ignored when no read grant occurred in the prior cycle.
- Reset during ACCESS or WAIT:
  - mem_req drops immediately and the partial access is abandoned.
  - After release, the block is in IDLE.

Test Plan:
- ALU op, rd=5, data 0x1234_5678, enable=1 → same values on mem_rd_* in the same cycle; mem_stall_req=0; mem_req never asserts.
- LW at 0x100 with grants every cycle; memory bytes 0x78,0x56,0x34,0x12 →
  - mem_a sequence 0x100..0x103;
  - stall high for 6 cycles;
  - DONE shows mem_rd_data=0x1234_5678, mem_rd_enable=1.
- LB and LBU at 0x20, byte 0x80 →
  - LB gives mem_rd_data=0xFFFF_FF80;
  - LBU gives 0x0000_0080;
  - LH/LHU on bytes 0x00,0x90 give 0xFFFF_9000 and 0x0000_9000.
- SH at 0x1FF, sdata 0xAABB_CCDD, grant withheld 3 cycles before each byte →
  - writes 0xDD@0x1FF, then 0xCC@0x200;
  - mem_a and mem_dout stable while waiting for a grant;
  - exactly 2 write grants.
- SW at 0xFFFF_FFFE → addresses wrap to 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0, 0x1.
- rst pulled low after the 2nd byte of an LW → mem_req=0 immediately; after release, an ALU op passes through with no stall.

Source files
------------

// File: rtl/mem.sv
// -----------------------------------------------------------------------------
// mem -- MEM stage of the RISC-V pipeline (between ex_mem and mem_wb).
//
// Non-memory instructions pass straight through, combinationally, to the
// mem_wb inputs. Loads and stores are broken into byte transfers on the
// memory controller's byte-wide port. The pipeline is stalled while a
// transfer sequence is in flight. Load bytes are assembled little-endian and
// sign- or zero-extended into the writeback value.
//
// Ports
//   clk            in   clock
//   rst            in   asynchronous reset, active low; forces all outputs to 0
//   ex_rd_data     in   [31:0] result from ex_mem (don't-care for stores)
//   ex_rd_addr     in   [4:0]  destination register
//   ex_rd_enable   in   register write enable
//   ex_mem_load    in   instruction is a load
//   ex_mem_store   in   instruction is a store (never together with load)
//   ex_mem_funct3  in   [2:0]  funct3: [1:0] size (00=1B, 01=2B, 1x=4B),
//                       [2] zero-extend loads
//   ex_mem_addr    in   [31:0] effective byte address (misaligned allowed)
//   ex_mem_sdata   in   [31:0] store data
//   mem_grant      in   controller accepted the byte presented this cycle
//   mem_din        in   [7:0]  read byte, valid the cycle after a read grant
//   mem_req        out  byte transfer request
//   mem_we         out  1 = write, 0 = read
//   mem_a          out  [31:0] byte address
//   mem_dout       out  [7:0]  write byte
//   mem_stall_req  out  hold IF/ID/EX and ex_mem
//   mem_rd_data    out  [31:0] to mem_wb
//   mem_rd_addr    out  [4:0]  to mem_wb
//   mem_rd_enable  out  to mem_wb
// -----------------------------------------------------------------------------
module mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_rd_data,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_rd_enable,
    input  logic        ex_mem_load,
    input  logic        ex_mem_store,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_sdata,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    output logic        mem_stall_req,
    output logic [31:0] mem_rd_data,
    output logic [4:0]  mem_rd_addr,
    output logic        mem_rd_enable
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;

    // Fields latched when an access is detected in IDLE.
    logic        op_store;
    logic [2:0]  funct3_q;
    logic [31:0] base_q;
    logic [31:0] sdata_q;
    logic [31:0] rd_data_q;
    logic [4:0]  rd_addr_q;
    logic        rd_enable_q;

    // issue_cnt: index of the byte currently presented to the controller.
    // recv_cnt : index of the next load byte to land in load_buf.
    logic [1:0]  issue_cnt;
    logic [1:0]  recv_cnt;
    logic [31:0] load_buf;

    // Delayed read-grant: marks mem_din as valid in the current cycle.
    logic        rd_valid_q;

    logic        is_access;
    logic        grant_read;
    logic [1:0]  last_idx;
    logic [31:0] load_value;

    assign is_access  = ex_mem_load | ex_mem_store;

    // Grants only count while a request is actually presented.
    assign grant_read = (state == S_ACCESS) & mem_grant & ~op_store;

    // Index of the final byte of the latched access size.
    // NOTE: every signal written in an always_comb gets a value on every path
    // (here via the default branch) so no latch is inferred.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    end

    // Extension of the assembled load bytes; funct3[2] selects zero-extension.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   load_value = {{24{~funct3_q[2] & load_buf[7]}},  load_buf[7:0]};
            2'b01:   load_value = {{16{~funct3_q[2] & load_buf[15]}}, load_buf[15:0]};
            default: load_value = load_buf;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential state: FSM, latched fields, byte counters and load buffer.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            op_store    <= 1'b0;
            funct3_q    <= 3'd0;
            base_q      <= 32'd0;
            sdata_q     <= 32'd0;
            rd_data_q   <= 32'd0;
            rd_addr_q   <= 5'd0;
            rd_enable_q <= 1'b0;
            issue_cnt   <= 2'd0;
            recv_cnt    <= 2'd0;
            load_buf    <= 32'd0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= grant_read;

            // A read byte arrives one cycle after its grant, in ACCESS or in
            // WAIT for the final byte.
            if (rd_valid_q) begin
                load_buf[{recv_cnt, 3'b000} +: 8] <= mem_din;
                recv_cnt                          <= recv_cnt + 2'd1;
            end

            case (state)
                S_IDLE: begin
                    if (is_access) begin
                        op_store    <= ex_mem_store;
                        funct3_q    <= ex_mem_funct3;
                        base_q      <= ex_mem_addr;
                        sdata_q     <= ex_mem_sdata;
                        rd_data_q   <= ex_rd_data;
                        rd_addr_q   <= ex_rd_addr;
                        rd_enable_q <= ex_rd_enable;
                        issue_cnt   <= 2'd0;
                        recv_cnt    <= 2'd0;
                        load_buf    <= 32'd0;
                        state       <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (mem_grant) begin
                        issue_cnt <= issue_cnt + 2'd1;
                        if (issue_cnt == last_idx) begin
                            // Stores are complete on the last grant; loads
                            // still need one cycle to receive the last byte.
                            state <= op_store ? S_DONE : S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    state <= S_DONE;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. IDLE is a combinational pass-through so ALU results reach
    // mem_wb with no added latency; stall is raised in the same cycle a
    // load/store shows up so ex_mem holds it. Everything is gated to 0 while
    // reset is asserted.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_a         = 32'd0;
        mem_dout      = 8'd0;
        mem_stall_req = 1'b0;
        mem_rd_data   = 32'd0;
        mem_rd_addr   = 5'd0;
        mem_rd_enable = 1'b0;

        if (rst) begin
            case (state)
                S_IDLE: begin
                    mem_rd_data = ex_rd_data;
                    mem_rd_addr = ex_rd_addr;
                    if (is_access) begin
                        mem_stall_req = 1'b1;
                    end else begin
                        mem_rd_enable = ex_rd_enable;
                    end
                end

                S_ACCESS: begin
                    mem_req       = 1'b1;
                    mem_we        = op_store;
                    // 32-bit add wraps naturally past 0xFFFF_FFFF.
                    mem_a         = base_q + {30'd0, issue_cnt};
                    mem_dout      = sdata_q[{issue_cnt, 3'b000} +: 8];
                    mem_stall_req = 1'b1;
                end

                S_WAIT: begin
                    mem_stall_req = 1'b1;
                end

                S_DONE: begin
                    mem_rd_data   = op_store ? rd_data_q : load_value;
                    mem_rd_addr   = rd_addr_q;
                    mem_rd_enable = rd_enable_q;
                end

                default: begin
                    mem_stall_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem.sv
// -----------------------------------------------------------------------------
// tb_mem -- scoreboard bench for the MEM stage.
// A driver presents one instruction at a time and pushes the expected byte
// transfers and writeback result into queues. A memory responder grants
// requests (optionally after a fixed number of withheld cycles) and returns
// read data. A monitor pops and compares whenever the DUT completes a byte
// transfer or presents a writeback result.
// -----------------------------------------------------------------------------
module tb_mem;

    logic        clk;
    logic        rst;
    logic [31:0] ex_rd_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_enable;
    logic        ex_mem_load;
    logic        ex_mem_store;
    logic [2:0]  ex_mem_funct3;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_sdata;
    logic        mem_grant;
    logic [7:0]  mem_din;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_stall_req;
    logic [31:0] mem_rd_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_enable;

    mem dut (
        .clk           (clk),
        .rst           (rst),
        .ex_rd_data    (ex_rd_data),
        .ex_rd_addr    (ex_rd_addr),
        .ex_rd_enable  (ex_rd_enable),
        .ex_mem_load   (ex_mem_load),
        .ex_mem_store  (ex_mem_store),
        .ex_mem_funct3 (ex_mem_funct3),
        .ex_mem_addr   (ex_mem_addr),
        .ex_mem_sdata  (ex_mem_sdata),
        .mem_grant     (mem_grant),
        .mem_din       (mem_din),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_a         (mem_a),
        .mem_dout      (mem_dout),
        .mem_stall_req (mem_stall_req),
        .mem_rd_data   (mem_rd_data),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_enable (mem_rd_enable)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } bus_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        en;
    } res_t;

    bus_t bus_q[$];
    res_t res_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Environment controls.
    int   grant_delay = 0;
    bit   stray_grant = 0;
    bit   inst_valid  = 0;
    logic [7:0] mem_model [logic [31:0]];

    // Responder state.
    int          wait_cnt  = 0;
    bit          prev_rd   = 0;
    logic [31:0] prev_addr = 32'd0;

    // Monitor state.
    bit          prev_req   = 0;
    bit          prev_grant = 0;
    logic        prev_we    = 1'b0;
    logic [31:0] prev_a     = 32'd0;
    logic [7:0]  prev_dout  = 8'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [7:0] data);
        bus_t b;
        b.we   = we;
        b.addr = addr;
        b.data = data;
        bus_q.push_back(b);
    endtask

    task automatic exp_res(input logic [31:0] data, input logic [4:0] addr, input logic en);
        res_t r;
        r.data = data;
        r.addr = addr;
        r.en   = en;
        res_q.push_back(r);
    endtask

    task automatic clear_inputs();
        ex_rd_data    = 32'd0;
        ex_rd_addr    = 5'd0;
        ex_rd_enable  = 1'b0;
        ex_mem_load   = 1'b0;
        ex_mem_store  = 1'b0;
        ex_mem_funct3 = 3'd0;
        ex_mem_addr   = 32'd0;
        ex_mem_sdata  = 32'd0;
    endtask

    // Present one instruction (called just after a rising edge), hold it
    // while stalled, and count the stall cycles.
    task automatic issue(input string name, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdd,
                         input logic [4:0] rda, input logic rde, input int exp_stall);
        int stall_cycles;
        bit done;
        stall_cycles  = 0;
        done          = 0;
        ex_mem_load   = ld;
        ex_mem_store  = st;
        ex_mem_funct3 = f3;
        ex_mem_addr   = addr;
        ex_mem_sdata  = sdata;
        ex_rd_data    = rdd;
        ex_rd_addr    = rda;
        ex_rd_enable  = rde;
        inst_valid    = 1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            #2;
            if (mem_stall_req) stall_cycles++;
            else done = 1;
        end
        check({name, "_completes"}, done, 1);
        check({name, "_stall_cycles"}, stall_cycles, exp_stall);
        @(posedge clk);
        #1;
        inst_valid = 0;
        clear_inputs();
    endtask

    // Memory controller model: grants after grant_delay withheld cycles and
    // returns the read byte one cycle after each read grant.
    initial begin
        mem_grant = 1'b0;
        mem_din   = 8'hEE;
        forever begin
            @(negedge clk);
            if (prev_rd) mem_din = mem_model.exists(prev_addr) ? mem_model[prev_addr] : 8'h00;
            else         mem_din = 8'hEE;
            if (!rst || !mem_req) begin
                wait_cnt  = 0;
                mem_grant = stray_grant && rst;
            end else if (wait_cnt >= grant_delay) begin
                mem_grant = 1'b1;
                wait_cnt  = 0;
            end else begin
                mem_grant = 1'b0;
                wait_cnt++;
            end
            prev_rd   = mem_grant && mem_req && !mem_we;
            prev_addr = mem_a;
        end
    end

    // Monitor: compares completed byte transfers, request stability while
    // waiting for a grant, and writeback results against the queues.
    initial begin
        bus_t b;
        res_t r;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (mem_req && mem_grant) begin
                    check("bus_xfer_expected", bus_q.size() != 0, 1);
                    if (bus_q.size() != 0) begin
                        b = bus_q.pop_front();
                        check("bus_we_addr", {mem_we, mem_a}, {b.we, b.addr});
                        if (b.we) check("bus_wdata", mem_dout, b.data);
                    end
                end
                if (prev_req && !prev_grant && mem_req)
                    check("bus_hold_while_waiting", {mem_we, mem_a, mem_dout}, {prev_we, prev_a, prev_dout});
                if (inst_valid && !mem_stall_req) begin
                    check("result_expected", res_q.size() != 0, 1);
                    if (res_q.size() != 0) begin
                        r = res_q.pop_front();
                        check("result_req_data_addr_en",
                              {mem_req, mem_rd_data, mem_rd_addr, mem_rd_enable},
                              {1'b0, r.data, r.addr, r.en});
                    end
                end
            end
            prev_req   = rst && mem_req;
            prev_grant = mem_grant;
            prev_we    = mem_we;
            prev_a     = mem_a;
            prev_dout  = mem_dout;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        clear_inputs();

        mem_model[32'h100] = 8'h78;
        mem_model[32'h101] = 8'h56;
        mem_model[32'h102] = 8'h34;
        mem_model[32'h103] = 8'h12;
        mem_model[32'h20]  = 8'h80;
        mem_model[32'h40]  = 8'h00;
        mem_model[32'h41]  = 8'h90;
        mem_model[32'h300] = 8'hEF;
        mem_model[32'h301] = 8'hBE;
        mem_model[32'h302] = 8'hAD;
        mem_model[32'h303] = 8'hDE;
        mem_model[32'h400] = 8'h01;
        mem_model[32'h401] = 8'h02;

        // Reset: outputs forced to 0 even with a live load on the inputs.
        ex_mem_load  = 1'b1;
        ex_mem_addr  = 32'h0000_0100;
        ex_rd_data   = 32'h1234_5678;
        ex_rd_addr   = 5'd5;
        ex_rd_enable = 1'b1;
        @(posedge clk);
        #1;
        check("reset_bus_outputs", {mem_req, mem_we, mem_a, mem_dout, mem_stall_req}, 0);
        check("reset_rd_outputs", {mem_rd_data, mem_rd_addr, mem_rd_enable}, 0);
        clear_inputs();
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU op: same-cycle pass-through, stray grants must not start anything.
        stray_grant = 1;
        exp_res(32'h1234_5678, 5'd5, 1'b1);
        issue("alu", 0, 0, 3'b000, 32'h0, 32'h0, 32'h1234_5678, 5'd5, 1'b1, 0);
        stray_grant = 0;

        // LW at 0x100, grants every cycle.
        grant_delay = 0;
        for (int i = 0; i < 4; i++) exp_bus(1'b0, 32'h100 + i, 8'h00);
        exp_res(32'h1234_5678, 5'd3, 1'b1);
        issue("lw", 1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1, 6);

        // LB / LBU on byte 0x80.
        exp_bus(1'b0, 32'h20, 8'h00);
        exp_res(32'hFFFF_FF80, 5'd4, 1'b1);
        issue("lb", 1, 0, 3'b000, 32'h20, 32'h0, 32'h0, 5'd4, 1'b1, 3);
        exp_bus(1'b0, 32'h20, 8'h00);
        exp_res(32'h0000_0080, 5'd6, 1'b1);
        issue("lbu", 1, 0, 3'b100, 32'h20, 32'h0, 32'h0, 5'd6, 1'b1, 3);

        // LH / LHU on bytes 0x00, 0x90.
        exp_bus(1'b0, 32'h40, 8'h00);
        exp_bus(1'b0, 32'h41, 8'h00);
        exp_res(32'hFFFF_9000, 5'd8, 1'b1);
        issue("lh", 1, 0, 3'b001, 32'h40, 32'h0, 32'h0, 5'd8, 1'b1, 4);
        exp_bus(1'b0, 32'h40, 8'h00);
        exp_bus(1'b0, 32'h41, 8'h00);
        exp_res(32'h0000_9000, 5'd10, 1'b1);
        issue("lhu", 1, 0, 3'b101, 32'h40, 32'h0, 32'h0, 5'd10, 1'b1, 4);

        // LW with two withheld cycles per byte; junk on mem_din in between.
        grant_delay = 2;
        for (int i = 0; i < 4; i++) exp_bus(1'b0, 32'h300 + i, 8'h00);
        exp_res(32'hDEAD_BEEF, 5'd11, 1'b1);
        issue("lw_slow", 1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd11, 1'b1, 14);

        // SH at 0x1FF, three withheld cycles before each byte.
        grant_delay = 3;
        exp_bus(1'b1, 32'h1FF, 8'hDD);
        exp_bus(1'b1, 32'h200, 8'hCC);
        exp_res(32'hDEAD_0001, 5'd7, 1'b0);
        issue("sh", 0, 1, 3'b001, 32'h1FF, 32'hAABB_CCDD, 32'hDEAD_0001, 5'd7, 1'b0, 9);

        // SW across the top of the address space.
        grant_delay = 0;
        exp_bus(1'b1, 32'hFFFF_FFFE, 8'h44);
        exp_bus(1'b1, 32'hFFFF_FFFF, 8'h33);
        exp_bus(1'b1, 32'h0000_0000, 8'h22);
        exp_bus(1'b1, 32'h0000_0001, 8'h11);
        exp_res(32'h0000_0000, 5'd0, 1'b0);
        issue("sw_wrap", 0, 1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0, 5'd0, 1'b0, 5);

        // Reset after the second byte of an LW.
        exp_bus(1'b0, 32'h400, 8'h00);
        exp_bus(1'b0, 32'h401, 8'h00);
        ex_mem_load   = 1'b1;
        ex_mem_funct3 = 3'b010;
        ex_mem_addr   = 32'h400;
        ex_rd_data    = 32'h5555_AAAA;
        ex_rd_addr    = 5'd12;
        ex_rd_enable  = 1'b1;
        n = 0;
        for (int c = 0; c < 50 && n < 2; c++) begin
            @(negedge clk);
            #2;
            if (mem_req && mem_grant) n++;
        end
        check("abort_two_grants_seen", n, 2);
        @(posedge clk);
        #1;
        check("abort_req_before_reset", mem_req, 1);
        rst = 1'b0;
        #1;
        check("abort_req_dropped", mem_req, 0);
        check("abort_all_outputs_zero",
              {mem_we, mem_a, mem_dout, mem_stall_req, mem_rd_data, mem_rd_addr, mem_rd_enable}, 0);
        clear_inputs();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_res(32'hCAFE_F00D, 5'd9, 1'b1);
        issue("alu_after_reset", 0, 0, 3'b000, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd9, 1'b1, 0);

        repeat (3) @(posedge clk);
        check("bus_queue_drained", bus_q.size(), 0);
        check("result_queue_drained", res_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
